// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer: walks (stage, index) pairs, fetches twiddles from ROM and streams them through a 2-entry FIFO.
// Optional macro TWSEQ_INVERSE_EN adds an inv input that negates (with saturation) every imaginary word.
module twiddle_seq #(
    parameter int WORDSIZE = 16,
    parameter int ADDRSIZE = 5,
    parameter int NUMADDR  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef TWSEQ_INVERSE_EN
    input  logic                inv,
`endif
    output logic                busy,
    output logic                done,
    output logic                rom_cs,
    output logic [ADDRSIZE-1:0] rom_addr,
    input  logic [WORDSIZE-1:0] rom_data1,
    input  logic [WORDSIZE-1:0] rom_data2,
    output logic [WORDSIZE-1:0] tw_re,
    output logic [WORDSIZE-1:0] tw_im,
    output logic [2:0]          tw_stage,
    output logic [ADDRSIZE-1:0] tw_index,
    output logic                tw_valid,
    input  logic                tw_ready,
    output logic                tw_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [WORDSIZE-1:0] re;
        logic [WORDSIZE-1:0] im;
        logic [2:0]          s;
        logic [ADDRSIZE-1:0] j;
    } entry_t;

    localparam logic [2:0]          LAST_S = 3'(ADDRSIZE);
    localparam logic [ADDRSIZE-1:0] LAST_J = ADDRSIZE'(NUMADDR - 1);

    state_t              state, state_next;
    logic [2:0]          s;
    logic [ADDRSIZE-1:0] j;
    logic                infl;
    logic [2:0]          infl_s;
    logic [ADDRSIZE-1:0] infl_j;
    entry_t              fifo [2];
    entry_t              head;
    logic                wr_ptr, rd_ptr;
    logic [1:0]          count, count_next;
    logic                pop, issue, last_issue;
    logic [WORDSIZE-1:0] cap_im;

    // Bit-reversed style twiddle address: keep the low s bits of j, left-justified in the address.
    function automatic logic [ADDRSIZE-1:0] tw_addr(input logic [2:0] stage,
                                                   input logic [ADDRSIZE-1:0] idx);
        logic [ADDRSIZE:0]   mask;
        logic [ADDRSIZE-1:0] masked;
        logic [2:0]          shamt;
        mask   = ((ADDRSIZE+1)'(1) << stage) - (ADDRSIZE+1)'(1);
        masked = idx & mask[ADDRSIZE-1:0];
        shamt  = LAST_S - stage;
        return masked << shamt;
    endfunction

`ifdef TWSEQ_INVERSE_EN
    localparam logic [WORDSIZE-1:0] MOST_NEG = {1'b1, {(WORDSIZE-1){1'b0}}};
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if (state == IDLE && start)
            inv_q <= inv;
    end

    assign cap_im = !inv_q ? rom_data2 :
                    (rom_data2 == MOST_NEG) ? ~MOST_NEG : -rom_data2;
`else
    assign cap_im = rom_data2;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        head       = fifo[rd_ptr];
        tw_valid   = (count != 2'd0);
        pop        = tw_valid && tw_ready;
        // Credit: room for one more word counting what is already on its way from the ROM.
        issue      = (state == RUN) && (((count + 2'(infl)) < 2'd2) || pop);
        last_issue = issue && (s == LAST_S) && (j == LAST_J);
        count_next = count + 2'(infl) - 2'(pop);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (count_next == 2'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign rom_cs   = busy;
    assign done     = (state == DONE);
    assign tw_re    = head.re;
    assign tw_im    = head.im;
    assign tw_stage = head.s;
    assign tw_index = head.j;
    assign tw_last  = tw_valid && (head.s == LAST_S) && (head.j == LAST_J);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s        <= '0;
            j        <= '0;
            rom_addr <= '0;
            infl     <= 1'b0;
            infl_s   <= '0;
            infl_j   <= '0;
        end else begin
            infl <= issue;
            if (state == IDLE && start) begin
                s <= '0;
                j <= '0;
            end else if (issue) begin
                rom_addr <= tw_addr(s, j);
                infl_s   <= s;
                infl_j   <= j;
                if (j == LAST_J) begin
                    j <= '0;
                    s <= s + 3'd1;
                end else begin
                    j <= j + ADDRSIZE'(1);
                end
            end
        end
    end

    // NOTE: the FIFO storage is reset too, because its head drives outputs that must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (infl) begin
                fifo[wr_ptr] <= '{re: rom_data1, im: cap_im, s: infl_s, j: infl_j};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_twiddle_seq.sv
// Self-checking bench for twiddle_seq: vector table over a full sequence plus stall, reset-abort and restart scenarios.
module tb_twiddle_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tw_ready = 1'b0;
    logic        busy, done, rom_cs, tw_valid, tw_last;
    logic [4:0]  rom_addr, tw_index;
    logic [15:0] rom_data1, rom_data2, tw_re, tw_im;
    logic [2:0]  tw_stage;
`ifdef TWSEQ_INVERSE_EN
    logic        inv = 1'b0;
`endif

    logic [15:0] rom_re_mem [32];
    logic [15:0] rom_im_mem [32];

    assign rom_data1 = rom_cs ? rom_re_mem[rom_addr] : 16'h0000;
    assign rom_data2 = rom_cs ? rom_im_mem[rom_addr] : 16'h0000;

    twiddle_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef TWSEQ_INVERSE_EN
        .inv(inv),
`endif
        .busy(busy), .done(done), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data1(rom_data1), .rom_data2(rom_data2),
        .tw_re(tw_re), .tw_im(tw_im), .tw_stage(tw_stage), .tw_index(tw_index),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_last(tw_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  s;
        logic [4:0]  j;
        logic        last;
    } xfer_t;

    xfer_t xfers [$];
    int    done_cyc = 0;
    int    done_count = 0;
    int    stall_viol = 0;
    bit    stalled_prev = 0;
    logic [40:0] held;

    // Transfer monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev && {tw_valid, tw_re, tw_im, tw_stage, tw_index} !== held)
                stall_viol++;
            stalled_prev = tw_valid && !tw_ready;
            held = {tw_valid, tw_re, tw_im, tw_stage, tw_index};
            if (tw_valid && tw_ready)
                xfers.push_back('{cyc, tw_re, tw_im, tw_stage, tw_index, tw_last});
            if (done) begin
                done_cyc = cyc;
                done_count++;
            end
        end else begin
            stalled_prev = 0;
        end
    end

    bit rand_ready = 0;
    initial forever begin
        @(posedge clk);
        #1;
        tw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int exp_addr(input int k);
        int st = k / 32;
        int jj = k % 32;
        return (jj % (1 << st)) * (1 << (5 - st));
    endfunction

    int start_cyc = 0;

    task automatic clear_log();
        xfers.delete();
        done_count = 0;
        done_cyc = 0;
        stall_viol = 0;
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_count > 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int nlast = 0;
        check({tag, "_count"}, 64'(xfers.size()), 64'd192);
        for (int k = 0; k < xfers.size() && k < 192; k++) begin
            int a = exp_addr(k);
            check($sformatf("%s_xfer%0d", tag, k),
                  {xfers[k].s, xfers[k].j, xfers[k].re, xfers[k].im},
                  {3'(k / 32), 5'(k % 32), rom_re_mem[a], rom_im_mem[a]});
            if (xfers[k].last) nlast++;
        end
        check({tag, "_last_count"}, 64'(nlast), 64'd1);
        if (xfers.size() > 0) begin
            check({tag, "_last_on_final"}, 64'(xfers[xfers.size()-1].last), 64'd1);
            check({tag, "_done_after_last"}, 64'(done_cyc), 64'(xfers[xfers.size()-1].cyc + 1));
        end
        check({tag, "_done_pulses"}, 64'(done_count), 64'd1);
    endtask

    typedef struct {
        int         k;
        logic [2:0] s;
        logic [4:0] j;
        logic [4:0] addr;
        logic       last;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{0,   3'd0, 5'd0,  5'd0,  1'b0};
        vecs[1] = '{31,  3'd0, 5'd31, 5'd0,  1'b0};
        vecs[2] = '{32,  3'd1, 5'd0,  5'd0,  1'b0};
        vecs[3] = '{33,  3'd1, 5'd1,  5'd16, 1'b0};
        vecs[4] = '{70,  3'd2, 5'd6,  5'd16, 1'b0};
        vecs[5] = '{109, 3'd3, 5'd13, 5'd20, 1'b0};
        vecs[6] = '{150, 3'd4, 5'd22, 5'd12, 1'b0};
        vecs[7] = '{173, 3'd5, 5'd13, 5'd13, 1'b0};
        vecs[8] = '{191, 3'd5, 5'd31, 5'd31, 1'b1};

        for (int a = 0; a < 32; a++) begin
            rom_re_mem[a] = 16'hA500 + 16'(a);
            rom_im_mem[a] = 16'h3C00 + 16'(a * 3);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, rom_cs, rom_addr, tw_re, tw_im, tw_stage, tw_index, tw_valid, tw_last}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", {busy, rom_cs, tw_valid, done}, 64'd0);

        // Run A: ready held high.
        clear_log();
        start_pulse();
        wait_done("runA", 400);
        check_stream("runA");
        if (xfers.size() > 0) begin
            check("runA_first_latency", 64'(xfers[0].cyc - start_cyc), 64'd3);
            check("runA_back_to_back", 64'(xfers[xfers.size()-1].cyc - xfers[0].cyc), 64'd191);
        end
        foreach (vecs[i]) begin
            if (vecs[i].k < xfers.size())
                check($sformatf("vec_k%0d", vecs[i].k),
                      {xfers[vecs[i].k].s, xfers[vecs[i].k].j, xfers[vecs[i].k].re, 7'd0, xfers[vecs[i].k].last},
                      {vecs[i].s, vecs[i].j, rom_re_mem[vecs[i].addr], 7'd0, vecs[i].last});
            else
                check($sformatf("vec_k%0d_present", vecs[i].k), 64'(xfers.size()), 64'(vecs[i].k + 1));
        end
        check("runA_idle_after", {busy, rom_cs, tw_valid}, 64'd0);

        // Run B: random backpressure and a start pulse while busy.
        rand_ready = 1;
        clear_log();
        start_pulse();
        repeat (20) @(negedge clk);
        check("runB_busy_mid", 64'(busy), 64'd1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("runB", 2000);
        check_stream("runB");
        check("runB_stall_stable", 64'(stall_viol), 64'd0);
        rand_ready = 0;
        repeat (4) @(negedge clk);

        // Run C: reset abort at s=2, j=7 and replay.
        clear_log();
        start_pulse();
        begin
            int n = 0;
            while (!(tw_valid && tw_stage == 3'd2 && tw_index == 5'd7) && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("runC_reach_s2_j7", 64'(n < 1000), 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("runC_async_reset_outputs",
              {busy, done, rom_cs, rom_addr, tw_re, tw_im, tw_stage, tw_index, tw_valid, tw_last}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
        repeat (6) @(negedge clk);
        check("runC_no_action", {busy, rom_cs, tw_valid, done}, 64'd0);
        check("runC_no_xfers", 64'(xfers.size()), 64'd0);
        start_pulse();
        wait_done("runC", 400);
        check_stream("runC");

`ifdef TWSEQ_INVERSE_EN
        // Run D: inverse mode with saturating negation.
        rom_im_mem[0]  = 16'h4000;
        rom_im_mem[16] = 16'h8000;
        clear_log();
        @(posedge clk);
        #1 inv = 1'b1;
        start_pulse();
        inv = 1'b0;
        wait_done("runD", 400);
        check("runD_count", 64'(xfers.size()), 64'd192);
        if (xfers.size() == 192) begin
            check("runD_im_4000", 64'(xfers[0].im), 64'h0000_C000);
            check("runD_im_8000", 64'(xfers[33].im), 64'h0000_7FFF);
            check("runD_im_plain", 64'(xfers[161].im), 64'(16'(16'h0000 - rom_im_mem[1])));
            check("runD_re_untouched", 64'(xfers[33].re), 64'(rom_re_mem[16]));
        end
        rom_im_mem[0]  = 16'h3C00;
        rom_im_mem[16] = 16'h3C00 + 16'(48);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
